// File: rtl/pps_tagger_pkg.sv
// pps_tagger_pkg: shared types for the PPS time-tagger.
// The tag record uses fixed maximum widths (64-bit count, 32-bit seq) so a single
// package type serves every CNT_W/SEQ_W instance; the top zero-extends into it.
package pps_tagger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam int TAG_CNT_MAX_W = 64;
    localparam int TAG_SEQ_MAX_W = 32;
    localparam int TAG_WIDTH_W   = 16;

    typedef struct packed {
        logic [TAG_CNT_MAX_W-1:0] count;
        logic [TAG_SEQ_MAX_W-1:0] seq;
        logic                     first;
        logic                     sat;
    } tag_t;

endpackage

// File: rtl/pps_tagger_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an asynchronous level, followed by
// a delay flop and registered one-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the input through the synchroniser and compare last stage with its delayed copy
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        dly_d  = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & dly_q;
    end

    // Synchroniser, delay and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pps_tagger.sv
// pps_tagger: synchronises the conditioned PPS line, applies a glitch holdoff,
// and tags accepted rising edges with the cycle interval and a sequence number.
// Tags leave through a single-entry valid/ready register; a tag that finds the
// register occupied is dropped and flagged in the sticky 'missed' bit.
// Optional macro PPS_TAGGER_WIDTH_EN adds tag_width (pulse high time) and
// moves tag emission to the synced falling edge.
module pps_tagger
    import pps_tagger_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SEQ_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pps_in,
    input  logic                   enable,
    output logic                   tag_valid,
    input  logic                   tag_ready,
    output logic [CNT_W-1:0]       tag_count,
    output logic [SEQ_W-1:0]       tag_seq,
    output logic                   tag_first,
    output logic                   tag_sat,
`ifdef PPS_TAGGER_WIDTH_EN
    output logic [TAG_WIDTH_W-1:0] tag_width,
`endif
    output logic                   missed,
    input  logic                   missed_clr
);

    localparam int              HO_W    = $clog2(HOLDOFF + 1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);

    logic pps_level, pps_rise, pps_fall;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_run;
    logic [SEQ_W-1:0]   seq_q, seq_d, seq_inc;
    logic [HO_W-1:0]    ho_q, ho_d;
    tag_t               tag_q, tag_d, new_tag, emit_tag;
    logic               valid_q, valid_d;
    logic               missed_q, missed_d;
    logic               accept, emit, rise_ok;

`ifdef PPS_TAGGER_WIDTH_EN
    tag_t                   pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [TAG_WIDTH_W-1:0] width_q, width_d;
    logic [TAG_WIDTH_W-1:0] tag_width_q, tag_width_d;
`endif

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(pps_in),
        .level   (pps_level),
        .rise    (pps_rise),
        .fall    (pps_fall)
    );

    assign cnt_run = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign seq_inc = seq_q + SEQ_W'(1);

    // FSM, cycle/sequence counters, tag register handshake and drop detection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seq_d    = seq_q;
        ho_d     = ho_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        missed_d = missed_q;
        accept   = 1'b0;
        emit     = 1'b0;
        new_tag  = '0;
        emit_tag = '0;
`ifdef PPS_TAGGER_WIDTH_EN
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        width_d      = width_q;
        tag_width_d  = tag_width_q;
        rise_ok      = ~pend_valid_q;
`else
        rise_ok      = 1'b1;
`endif

        if (valid_q && tag_ready) valid_d = 1'b0;
        if (missed_clr) missed_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = ARMED;
            end
            ARMED, RUN: begin
                cnt_d = cnt_run;
                if (enable && pps_rise && rise_ok) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                    ho_d    = HO_LOAD;
                end
            end
            HOLD: begin
                cnt_d = cnt_run;
                if (ho_q == '0) state_d = RUN;
                else            ho_d = ho_q - HO_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            cnt_d         = CNT_W'(1);
            seq_d         = seq_inc;
            new_tag.count = TAG_CNT_MAX_W'(cnt_q);
            new_tag.seq   = TAG_SEQ_MAX_W'(seq_inc);
            new_tag.first = (state_q == ARMED);
            new_tag.sat   = &cnt_q;
        end

`ifdef PPS_TAGGER_WIDTH_EN
        if (accept) begin
            pend_d       = new_tag;
            pend_valid_d = 1'b1;
            width_d      = TAG_WIDTH_W'(1);
        end else if (pend_valid_q && !(&width_q)) begin
            width_d = width_q + TAG_WIDTH_W'(1);
        end
        if (pend_valid_q && pps_fall) begin
            emit         = 1'b1;
            emit_tag     = pend_q;
            pend_valid_d = 1'b0;
        end
`else
        emit     = accept;
        emit_tag = new_tag;
`endif

        if (emit) begin
            if (!valid_q || tag_ready) begin
                tag_d   = emit_tag;
                valid_d = 1'b1;
`ifdef PPS_TAGGER_WIDTH_EN
                tag_width_d = width_q;
`endif
            end else begin
                missed_d = 1'b1;
            end
        end

        if (!enable) state_d = IDLE;
    end

    // State, counter and tag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            seq_q    <= '0;
            ho_q     <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
            ho_q     <= ho_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
        end
    end

`ifdef PPS_TAGGER_WIDTH_EN
    // Pending-tag and pulse-width registers for falling-edge emission
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            width_q      <= '0;
            tag_width_q  <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            width_q      <= width_d;
            tag_width_q  <= tag_width_d;
        end
    end

    assign tag_width = tag_width_q;

    logic sync_unused;
    assign sync_unused = pps_level;
`else
    logic sync_unused;
    assign sync_unused = pps_level ^ pps_fall;
`endif

    logic tag_hi_unused;
    assign tag_hi_unused = (|(tag_q.count >> CNT_W)) | (|(tag_q.seq >> SEQ_W));

    assign tag_valid = valid_q;
    assign tag_count = tag_q.count[CNT_W-1:0];
    assign tag_seq   = tag_q.seq[SEQ_W-1:0];
    assign tag_first = tag_q.first;
    assign tag_sat   = tag_q.sat;
    assign missed    = missed_q;

endmodule

// File: tb/tb_pps_tagger.sv
// tb_pps_tagger: directed self-checking bench for pps_tagger.
// Main instance uses CNT_W=32, HOLDOFF=1000 with 3000-cycle PPS spacing;
// a second instance with CNT_W=8, HOLDOFF=20 exercises counter saturation.
module tb_pps_tagger;

    localparam int GAP = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        pps_m = 1'b0, enable_m = 1'b0, ready_m = 1'b0, clr_m = 1'b0;
    logic        valid_m, first_m, sat_m, missed_m;
    logic [31:0] count_m;
    logic [15:0] seq_m;

    logic        pps_s = 1'b0, enable_s = 1'b0, ready_s = 1'b0, clr_s = 1'b0;
    logic        valid_s, first_s, sat_s, missed_s;
    logic [7:0]  count_s;
    logic [15:0] seq_s;

`ifdef PPS_TAGGER_WIDTH_EN
    logic [15:0] width_m, width_s;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_seq = 0;
    int since_m = 0;
    int since_s = 0;

    pps_tagger #(.CNT_W(32), .SEQ_W(16), .SYNC_STAGES(2), .HOLDOFF(1000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pps_in    (pps_m),
        .enable    (enable_m),
        .tag_valid (valid_m),
        .tag_ready (ready_m),
        .tag_count (count_m),
        .tag_seq   (seq_m),
        .tag_first (first_m),
        .tag_sat   (sat_m),
`ifdef PPS_TAGGER_WIDTH_EN
        .tag_width (width_m),
`endif
        .missed    (missed_m),
        .missed_clr(clr_m)
    );

    pps_tagger #(.CNT_W(8), .SEQ_W(16), .SYNC_STAGES(2), .HOLDOFF(20)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .pps_in    (pps_s),
        .enable    (enable_s),
        .tag_valid (valid_s),
        .tag_ready (ready_s),
        .tag_count (count_s),
        .tag_seq   (seq_s),
        .tag_first (first_s),
        .tag_sat   (sat_s),
`ifdef PPS_TAGGER_WIDTH_EN
        .tag_width (width_s),
`endif
        .missed    (missed_s),
        .missed_clr(clr_s)
    );

    always #5 clk = ~clk;

    // Advance n clock cycles, leaving time 1 unit after the rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            since_m++;
            since_s++;
        end
    endtask

    // Raise main PPS exactly 'gap' cycles after its previous rise
    task automatic raise_m(input int gap);
        if (since_m < gap) tick(gap - since_m);
        pps_m   = 1'b1;
        since_m = 0;
    endtask

    task automatic raise_s(input int gap);
        if (since_s < gap) tick(gap - since_s);
        pps_s   = 1'b1;
        since_s = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        pps_m = 1'b1; pps_s = 1'b1;
        tick(8);
        pps_m = 1'b0; pps_s = 1'b0;
        tick(8);
        n_cmp++; if (valid_m !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid: got %b want 0", valid_m); end
        n_cmp++; if (count_m !== 32'd0) begin n_bad++; $display("[TB] FAIL rst_count: got %0d want 0", count_m); end
        n_cmp++; if (seq_m !== 16'd0) begin n_bad++; $display("[TB] FAIL rst_seq: got %0d want 0", seq_m); end
        n_cmp++; if ({first_m, sat_m, missed_m} !== 3'b000) begin n_bad++; $display("[TB] FAIL rst_flags: got %b want 000", {first_m, sat_m, missed_m}); end
        n_cmp++; if ({valid_s, first_s, sat_s, missed_s, count_s} !== 12'd0) begin n_bad++; $display("[TB] FAIL rst_sat_inst: got %h want 0", {valid_s, first_s, sat_s, missed_s, count_s}); end
    endtask

    task automatic test_nominal;
        ready_m  = 1'b1;
        enable_m = 1'b1;
        tick(2);
        raise_m(0);
        tick(3);
        n_cmp++; if (valid_m !== 1'b0) begin n_bad++; $display("[TB] FAIL nom_latency_early: got %b want 0", valid_m); end
        tick(1);
        exp_seq++;
        n_cmp++; if (valid_m !== 1'b1) begin n_bad++; $display("[TB] FAIL nom_latency: got %b want 1", valid_m); end
        n_cmp++; if (first_m !== 1'b1) begin n_bad++; $display("[TB] FAIL nom_first1: got %b want 1", first_m); end
        n_cmp++; if (seq_m !== 16'(exp_seq)) begin n_bad++; $display("[TB] FAIL nom_seq1: got %0d want %0d", seq_m, exp_seq); end
        pps_m = 1'b0;
        raise_m(GAP);
        tick(4);
        exp_seq++;
        n_cmp++; if (valid_m !== 1'b1) begin n_bad++; $display("[TB] FAIL nom_valid2: got %b want 1", valid_m); end
        n_cmp++; if (count_m !== 32'(GAP)) begin n_bad++; $display("[TB] FAIL nom_count2: got %0d want %0d", count_m, GAP); end
        n_cmp++; if (seq_m !== 16'(exp_seq)) begin n_bad++; $display("[TB] FAIL nom_seq2: got %0d want %0d", seq_m, exp_seq); end
        n_cmp++; if ({first_m, sat_m} !== 2'b00) begin n_bad++; $display("[TB] FAIL nom_flags2: got %b want 00", {first_m, sat_m}); end
        pps_m = 1'b0;
    endtask

    task automatic test_glitch;
        logic seen;
        seen = 1'b0;
        tick(500 - since_m);
        pps_m = 1'b1;
        tick(5);
        pps_m = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick(1);
            if (valid_m) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_no_tag: got %b want 0", seen); end
        raise_m(GAP);
        tick(4);
        exp_seq++;
        n_cmp++; if (count_m !== 32'(GAP)) begin n_bad++; $display("[TB] FAIL glitch_count: got %0d want %0d", count_m, GAP); end
        n_cmp++; if (seq_m !== 16'(exp_seq)) begin n_bad++; $display("[TB] FAIL glitch_seq: got %0d want %0d", seq_m, exp_seq); end
        pps_m = 1'b0;
        tick(2);
    endtask

    task automatic test_backpressure;
        int held;
        ready_m = 1'b0;
        raise_m(GAP);
        tick(4);
        exp_seq++;
        held = exp_seq;
        n_cmp++; if ({valid_m, missed_m} !== 2'b10) begin n_bad++; $display("[TB] FAIL bp_first: got %b want 10", {valid_m, missed_m}); end
        pps_m = 1'b0;
        raise_m(GAP);
        tick(4);
        exp_seq++;
        n_cmp++; if (seq_m !== 16'(held)) begin n_bad++; $display("[TB] FAIL bp_retained_seq: got %0d want %0d", seq_m, held); end
        n_cmp++; if (missed_m !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_missed: got %b want 1", missed_m); end
        pps_m = 1'b0;
        ready_m = 1'b1;
        tick(1);
        n_cmp++; if (valid_m !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_drain: got %b want 0", valid_m); end
        raise_m(GAP);
        tick(4);
        exp_seq++;
        n_cmp++; if (seq_m !== 16'(exp_seq)) begin n_bad++; $display("[TB] FAIL bp_next_seq: got %0d want %0d", seq_m, exp_seq); end
        n_cmp++; if (count_m !== 32'(GAP)) begin n_bad++; $display("[TB] FAIL bp_next_count: got %0d want %0d", count_m, GAP); end
        pps_m = 1'b0;
        clr_m = 1'b1;
        tick(1);
        clr_m = 1'b0;
        n_cmp++; if (missed_m !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_clear: got %b want 0", missed_m); end
    endtask

    task automatic test_drop_wins;
        int held;
        ready_m = 1'b0;
        raise_m(GAP);
        tick(4);
        exp_seq++;
        held = exp_seq;
        pps_m = 1'b0;
        raise_m(GAP);
        tick(3);
        clr_m = 1'b1;
        tick(1);
        clr_m = 1'b0;
        exp_seq++;
        n_cmp++; if (missed_m !== 1'b1) begin n_bad++; $display("[TB] FAIL drop_wins_missed: got %b want 1", missed_m); end
        n_cmp++; if (seq_m !== 16'(held)) begin n_bad++; $display("[TB] FAIL drop_wins_seq: got %0d want %0d", seq_m, held); end
        pps_m = 1'b0;
        clr_m = 1'b1;
        tick(1);
        clr_m = 1'b0;
        n_cmp++; if (missed_m !== 1'b0) begin n_bad++; $display("[TB] FAIL drop_wins_clear: got %b want 0", missed_m); end
    endtask

    task automatic test_back_to_back;
        raise_m(GAP);
        tick(3);
        ready_m = 1'b1;
        tick(1);
        exp_seq++;
        n_cmp++; if (valid_m !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_valid: got %b want 1", valid_m); end
        n_cmp++; if (seq_m !== 16'(exp_seq)) begin n_bad++; $display("[TB] FAIL b2b_seq: got %0d want %0d", seq_m, exp_seq); end
        n_cmp++; if (count_m !== 32'(GAP)) begin n_bad++; $display("[TB] FAIL b2b_count: got %0d want %0d", count_m, GAP); end
        n_cmp++; if (missed_m !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_missed: got %b want 0", missed_m); end
        pps_m = 1'b0;
        tick(1);
        n_cmp++; if (valid_m !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_drain: got %b want 0", valid_m); end
    endtask

    task automatic test_enable_drop;
        int held;
        ready_m = 1'b0;
        raise_m(GAP);
        tick(4);
        exp_seq++;
        held = exp_seq;
        pps_m = 1'b0;
        tick(100);
        enable_m = 1'b0;
        tick(3);
        enable_m = 1'b1;
        tick(2);
        n_cmp++; if ({valid_m, seq_m} !== {1'b1, 16'(held)}) begin n_bad++; $display("[TB] FAIL en_old_tag: got %b/%0d want 1/%0d", valid_m, seq_m, held); end
        ready_m = 1'b1;
        tick(1);
        n_cmp++; if (valid_m !== 1'b0) begin n_bad++; $display("[TB] FAIL en_old_read: got %b want 0", valid_m); end
        raise_m(300);
        tick(4);
        exp_seq++;
        n_cmp++; if (valid_m !== 1'b1) begin n_bad++; $display("[TB] FAIL en_new_valid: got %b want 1", valid_m); end
        n_cmp++; if (first_m !== 1'b1) begin n_bad++; $display("[TB] FAIL en_new_first: got %b want 1", first_m); end
        n_cmp++; if (seq_m !== 16'(exp_seq)) begin n_bad++; $display("[TB] FAIL en_new_seq: got %0d want %0d", seq_m, exp_seq); end
        pps_m = 1'b0;
        tick(2);
    endtask

    task automatic test_saturation;
        ready_s  = 1'b1;
        enable_s = 1'b1;
        tick(2);
        raise_s(0);
        tick(4);
        n_cmp++; if ({valid_s, first_s, seq_s} !== {1'b1, 1'b1, 16'd1}) begin n_bad++; $display("[TB] FAIL sat_first: got %b/%b/%0d want 1/1/1", valid_s, first_s, seq_s); end
        pps_s = 1'b0;
        raise_s(300);
        tick(4);
        n_cmp++; if (count_s !== 8'd255) begin n_bad++; $display("[TB] FAIL sat_count: got %0d want 255", count_s); end
        n_cmp++; if (sat_s !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_flag: got %b want 1", sat_s); end
        pps_s = 1'b0;
        raise_s(100);
        tick(4);
        n_cmp++; if (count_s !== 8'd100) begin n_bad++; $display("[TB] FAIL sat_recover_count: got %0d want 100", count_s); end
        n_cmp++; if ({sat_s, first_s, seq_s} !== {1'b0, 1'b0, 16'd3}) begin n_bad++; $display("[TB] FAIL sat_recover_flags: got %b/%b/%0d want 0/0/3", sat_s, first_s, seq_s); end
        pps_s = 1'b0;
    endtask

    task automatic test_async_reset;
        ready_m = 1'b0;
        raise_m(GAP);
        tick(4);
        n_cmp++; if (valid_m !== 1'b1) begin n_bad++; $display("[TB] FAIL ar_pre_valid: got %b want 1", valid_m); end
        pps_m = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({valid_m, missed_m, seq_m} !== 18'd0) begin n_bad++; $display("[TB] FAIL ar_cleared: got %b/%b/%0d want 0/0/0", valid_m, missed_m, seq_m); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        $display("[TB] pps_tagger bench start");
        test_reset();
        test_nominal();
        test_glitch();
        test_backpressure();
        test_drop_wins();
        test_back_to_back();
        test_enable_drop();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
